// File: rtl/bin_a_bcd.sv
// bin_a_bcd: sequential binary-to-BCD converter (shift-and-add-3).
// One iteration per input bit. INIT/DONE handshake; BCD output is held
// in a register and changes only when a conversion completes.
module bin_a_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INIT,
  input  logic [WIDTH-1:0]      BIN,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_END   = 2'd3
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    bin_r;
  logic [4*DIGITS-1:0] scr;
  logic [4*DIGITS-1:0] scr_adj;
  logic [4*DIGITS-1:0] scr_next;
  logic [4*DIGITS-1:0] bcd_r;
  logic [CW-1:0]       cnt;
  logic                busy_r;
  logic                done_r;

  // Per-digit add-3 on digits >= 5, then the left shift pulling in BIN_R's MSB
  always_comb begin
    scr_adj = scr;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scr[4*k +: 4] >= 4'd5) begin
        scr_adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
      end
    end
    scr_next = {scr_adj[4*DIGITS-2:0], bin_r[WIDTH-1]};
  end

  // Control FSM and datapath; BUSY/DONE are registered alongside the state
  // so they always equal the decode of the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      bin_r  <= '0;
      scr    <= '0;
      cnt    <= '0;
      bcd_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INIT) begin
            state  <= S_LOAD;
            busy_r <= 1'b1;
          end
        end
        S_LOAD: begin
          bin_r <= BIN;
          scr   <= '0;
          cnt   <= CW'(WIDTH);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          scr   <= scr_next;
          bin_r <= {bin_r[WIDTH-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd_r  <= scr_next;
            state  <= S_END;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        S_END: begin
          if (!INIT) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign BCD  = bcd_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_bin_a_bcd.sv
// Directed bench for bin_a_bcd with an expected-result queue.
module tb_bin_a_bcd;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        INIT = 1'b0;
  logic [15:0] BIN = '0;
  logic [19:0] BCD;
  logic        BUSY;
  logic        DONE;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] exp_q[$];
  logic [19:0] prev_bcd = '0;

  bin_a_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .INIT(INIT),
    .BIN (BIN),
    .BCD (BCD),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Decimal reference: digit k = (v / 10^k) % 10
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Cycle 0 is the current cycle (DUT idle). hold keeps INIT high throughout;
  // disturb changes BIN and toggles INIT during the shift phase.
  task automatic run_conv(input logic [15:0] b, input bit hold, input bit disturb);
    int          cyc;
    logic [19:0] e;
    BIN  = b;
    INIT = 1'b1;
    exp_q.push_back(to_bcd(int'(b)));
    tick();
    cyc = 1;
    check("load_busy", 32'(BUSY), 32'd1);
    check("load_done", 32'(DONE), 32'd0);
    if (!hold) INIT = 1'b0;
    while (!DONE && cyc < 100) begin
      check("bcd_hold", 32'(BCD), 32'(prev_bcd));
      if (disturb) begin
        if (cyc == 5) begin BIN = 16'd1; INIT = 1'b1; end
        if (cyc == 7) INIT = 1'b0;
        if (cyc == 8) INIT = 1'b1;
        if (cyc == 9) INIT = 1'b0;
      end
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'd18);
    check("end_busy", 32'(BUSY), 32'd0);
    e = exp_q.pop_front();
    check("result", 32'(BCD), 32'(e));
    prev_bcd = e;
    if (!hold) begin
      tick();
      check("done_fall", 32'(DONE), 32'd0);
      check("idle_bcd", 32'(BCD), 32'(e));
    end
  endtask

  initial begin
    // Reset with INIT held high
    RST  = 1'b1;
    INIT = 1'b1;
    tick();
    tick();
    check("rst_bcd", 32'(BCD), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    run_conv(16'd5, 1'b0, 1'b0);

    // Basic and boundary values
    run_conv(16'd181, 1'b0, 1'b0);
    run_conv(16'd0, 1'b0, 1'b0);
    run_conv(16'd65535, 1'b0, 1'b0);
    run_conv(16'd9999, 1'b0, 1'b0);

    // BIN change and INIT toggling during S_SHIFT are ignored
    run_conv(16'd255, 1'b0, 1'b1);

    // Level INIT: one conversion, DONE held, no retrigger
    run_conv(16'd100, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      tick();
      check("lvl_done", 32'(DONE), 32'd1);
      check("lvl_busy", 32'(BUSY), 32'd0);
    end
    check("lvl_bcd", 32'(BCD), 32'h00100);
    INIT = 1'b0;
    tick();
    check("lvl_idle_done", 32'(DONE), 32'd0);
    check("lvl_idle_busy", 32'(BUSY), 32'd0);
    run_conv(16'd42, 1'b0, 1'b0);

    // A few pseudo-random values
    for (int i = 0; i < 3; i++) begin
      run_conv(16'($urandom), 1'b0, 1'b0);
    end

    // Mid-conversion reset at cycle 9
    BIN  = 16'd999;
    INIT = 1'b1;
    tick();
    INIT = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    check("mid_busy_pre", 32'(BUSY), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_bcd", 32'(BCD), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    prev_bcd = '0;
    tick();
    check("mid_no_restart", 32'(BUSY), 32'd0);
    run_conv(16'd37, 1'b0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
